// File: rtl/tlights_pkg.sv
// Shared aspect encodings, monitor enums and aspect-legality helpers for the
// traffic-light safety monitor.
package tlights_pkg;

  localparam logic [2:0] ASPECT_R  = 3'b100;
  localparam logic [2:0] ASPECT_RA = 3'b110;
  localparam logic [2:0] ASPECT_G  = 3'b001;
  localparam logic [2:0] ASPECT_A  = 3'b010;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    FC_NONE       = 2'd0,
    FC_PATTERN    = 2'd1,
    FC_TRANSITION = 2'd2,
    FC_STUCK      = 2'd3
  } fault_code_t;

  function automatic logic is_aspect(input logic [2:0] a);
    return (a == ASPECT_R) || (a == ASPECT_RA) || (a == ASPECT_G) || (a == ASPECT_A);
  endfunction

  // Both arguments are assumed to already be legal aspects.
  function automatic logic legal_next(input logic [2:0] prev, input logic [2:0] cur);
    logic ok;
    ok = 1'b0;
    if (cur == prev) begin
      ok = 1'b1;
    end else begin
      case (prev)
        ASPECT_R:  ok = (cur == ASPECT_RA);
        ASPECT_RA: ok = (cur == ASPECT_G);
        ASPECT_G:  ok = (cur == ASPECT_A);
        ASPECT_A:  ok = (cur == ASPECT_R);
        default:   ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/tlights_flasher.sv
// Fail-safe amber flash generator: phase toggles every FLASH_HALF cycles and
// restarts high with a fresh count whenever start is pulsed.
module tlights_flasher #(
  parameter int FLASH_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic flash
);

  localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_phase;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CW'(FLASH_HALF - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign flash = r_phase;

endmodule

// File: rtl/tlights_monitor.sv
// Aspect safety monitor and lamp driver; TLIGHTS_MON_STUCK_EN adds the
// dwell counter and stuck-aspect (code 3) detection.
//
// state | meaning
// INIT  | lamps red, waiting for the sequencer to present R
// TRACK | lamps follow rag, every sample checked against the last one
// FAULT | sticky, flashing amber until reset
module tlights_monitor
  import tlights_pkg::*;
#(
  parameter int FLASH_HALF = 2,
  parameter int MAX_DWELL  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rag,
  output logic [2:0] lamp,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] mon_state
);

  if (FLASH_HALF < 1) begin : g_chk_flash
    $error("FLASH_HALF must be at least 1");
  end
  if (MAX_DWELL < 2) begin : g_chk_dwell
    $error("MAX_DWELL must be at least 2");
  end

  mon_state_t  r_state;
  fault_code_t r_code;
  logic [2:0]  r_lamp;
  logic [2:0]  r_prev;
  fault_code_t w_viol;
  logic        w_stuck;
  logic        w_flash;
  logic        w_start;

`ifdef TLIGHTS_MON_STUCK_EN
  localparam int DW = $clog2(MAX_DWELL + 1);
  logic [DW-1:0] r_dwell;

  // The sample that would make MAX_DWELL+1 identical samples in a row.
  assign w_stuck = (rag == r_prev) && (r_dwell == DW'(MAX_DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst || (r_state != TRACK)) begin
      r_dwell <= '0;
    end else if (rag != r_prev) begin
      r_dwell <= '0;
    end else if (r_dwell != DW'(MAX_DWELL)) begin
      r_dwell <= r_dwell + 1'b1;
    end
  end
`else
  assign w_stuck = 1'b0;
`endif

  always_comb begin
    w_viol = FC_NONE;
    case (r_state)
      INIT: begin
        if (!is_aspect(rag)) w_viol = FC_PATTERN;
      end
      TRACK: begin
        if (!is_aspect(rag))             w_viol = FC_PATTERN;
        else if (!legal_next(r_prev, rag)) w_viol = FC_TRANSITION;
        else if (w_stuck)                w_viol = FC_STUCK;
      end
      default: w_viol = FC_NONE;
    endcase
  end

  assign w_start = (w_viol != FC_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_code  <= FC_NONE;
      r_lamp  <= ASPECT_R;
      r_prev  <= ASPECT_R;
    end else if (w_viol != FC_NONE) begin
      r_state <= FAULT;
      r_code  <= w_viol;
    end else begin
      case (r_state)
        INIT: begin
          if (rag == ASPECT_R) begin
            r_state <= TRACK;
            r_lamp  <= rag;
            r_prev  <= rag;
          end
        end
        TRACK: begin
          r_lamp <= rag;
          r_prev <= rag;
        end
        default: ;
      endcase
    end
  end

  tlights_flasher #(.FLASH_HALF(FLASH_HALF)) u_flasher (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .flash (w_flash)
  );

  // Offending aspects never reach r_lamp; the FAULT mux takes over on entry.
  assign lamp       = (r_state == FAULT) ? {1'b0, w_flash, 1'b0} : r_lamp;
  assign fault      = (r_state == FAULT);
  assign fault_code = r_code;
  assign mon_state  = r_state;

endmodule
